ntt_stage_sched: RTL and testbench
==================================

Name: ntt_stage_sched

Overview:
- Sequencer for one in-place Cooley-Tukey NTT over N = 2^LOGN coefficients.
- Issues one butterfly per cycle to a fixed-latency butterfly datapath of depth PIPE; the datapath is built on the team's delay-line style.
- Generates dual-port read and twiddle addresses, and delays the write-back addresses by PIPE cycles.
- Enforces a drain barrier between stages, so stage s+1 never reads data still in flight from stage s.

Parameters:
- LOGN, 8, log2 of transform size N (N = 2^LOGN, LOGN >= 2).
- PIPE, 8, butterfly datapath latency in cycles, read issue to write-back (PIPE >= 1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately).
- start  input  1  request one transform; sampled only in IDLE.
- ready  output  1  1 in IDLE.
- busy  output  1  1 in RUN or DRAIN.
- done  output  1  one-cycle pulse in DONE state.
- stage  output  LOGN  current stage index s, 0..LOGN-1.
- rd_en  output  1  butterfly issue strobe.
- rd_top  output  LOGN  top operand address.
- rd_bot  output  LOGN  bottom operand address.
- tw_addr  output  LOGN  twiddle ROM address.
- wr_en  output  1  write-back strobe, equals rd_en delayed PIPE cycles.
- wr_top  output  LOGN  rd_top delayed PIPE cycles.
- wr_bot  output  LOGN  rd_bot delayed PIPE cycles.

Behaviour:
- Reset (reset=0, async): state=IDLE, stage=0, j=0, inflight=0, all delay taps cleared.
  - Outputs during reset: ready=1, all other outputs 0.
  - Reset mid-transform discards in-flight writes; no wr_en follows reset release.
- Registered outputs: rd_en/rd_top/rd_bot/tw_addr are registers, valid in the RUN cycle they assert.
- States:
  - IDLE: start=1 -> RUN, stage=0, j=0.
  - RUN: rd_en=1 each cycle, j++. When j = N/2-1 is issued -> DRAIN.
  - DRAIN: rd_en=0. Leave when inflight=0.
    - If stage = LOGN-1 -> DONE.
    - Else stage++, j=0 -> RUN.
  - DONE: done=1 for one cycle -> IDLE.
- Address generation:
  - d = N >> (s+1), g = j / d, k = j mod d.
  - rd_top = g*2d + k, rd_bot = rd_top + d, tw_addr = (1<<s) + g.
  - All arithmetic is LOGN bits; d is a power of two, so divide/mod are shift/mask.
- inflight counter (width clog2(N/2+PIPE)+1):
  - +1 on rd_en, -1 on wr_en; unchanged when both occur in the same cycle.
  - Never exceeds min(N/2, PIPE).
- Write-back delay: wr_en/wr_top/wr_bot come from a PIPE-deep internal delay of {rd_en, rd_top, rd_bot}.
  - wr_en at cycle t+PIPE iff rd_en at cycle t.
- Stage timing: each stage occupies N/2 + PIPE + 1 cycles (RUN + DRAIN).
  - The first RUN cycle follows the start-sampling edge.
- start rules:
  - start outside IDLE is ignored; it is not queued.
  - start held high through DONE starts a new transform on the cycle IDLE is re-entered.

Optional Feature:
- Macro: NTT_SCHED_STALL_EN.
- Defined:
  - Adds port stall (input, 1), registered-free.
  - In RUN, stall=1 suppresses rd_en and freezes j/stage; issue resumes with the same j when stall=0.
  - In-flight operations and the write-back delay continue unaffected.
  - Each stall cycle extends the stage by one cycle.
  - stall is ignored in IDLE, DRAIN and DONE.
- Undefined: no stall port; issue is never interrupted.

Test Plan:
- LOGN=3, PIPE=4, start pulse at cycle 0 -> rd_en cycles 1-4 with (top,bot,tw) = (0,4,1),(1,5,1),(2,6,1),(3,7,1); wr_en cycles 5-8 with the same pairs.
- Same run -> stage 1 issues (0,2,2),(1,3,2),(4,6,3),(5,7,3) at cycles 10-13; stage 2 issues (0,1,4),(2,3,5),(4,5,6),(6,7,7) at cycles 19-22; done=1 at cycle 28 only; ready=1 at cycle 29.
- Drain check, LOGN=3, PIPE=8 -> no rd_en with stage=1 before the last stage-0 wr_en; inflight peaks at 4 and reads 0 on DRAIN exit.
- reset=0 asserted at cycle 6 of the first test -> outputs cleared the same cycle; no wr_en after release; start at release+1 gives a fresh stage-0 sequence from (0,4,1).
- start pulses at cycles 3 and 20 during busy -> ignored; exactly one done; with start held high the whole time -> back-to-back transforms, done every 29 cycles.
- With NTT_SCHED_STALL_EN: stall=1 at cycles 2-3 -> rd_en at cycles 1,4,5,6, addresses unchanged in order; done at cycle 30.

Source files
------------

// File: rtl/ntt_stage_sched.sv
// Butterfly issue sequencer for an in-place Cooley-Tukey NTT over 2^LOGN points.
// Optional: define NTT_SCHED_STALL_EN to add a stall input that pauses issue in RUN.
module ntt_stage_sched #(
   parameter int LOGN = 8,
   parameter int PIPE = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
`ifdef NTT_SCHED_STALL_EN
   input  logic            stall,
`endif
   output logic            ready,
   output logic            busy,
   output logic            done,
   output logic [LOGN-1:0] stage,
   output logic            rd_en,
   output logic [LOGN-1:0] rd_top,
   output logic [LOGN-1:0] rd_bot,
   output logic [LOGN-1:0] tw_addr,
   output logic            wr_en,
   output logic [LOGN-1:0] wr_top,
   output logic [LOGN-1:0] wr_bot
);

   localparam int N    = 1 << LOGN;
   localparam int HALF = N / 2;
   localparam int IW   = $clog2(HALF + PIPE) + 1;
   localparam int DW   = 2 * LOGN + 1;
   localparam logic [LOGN-1:0] ONE    = LOGN'(1);
   localparam logic [LOGN-1:0] J_LAST = LOGN'(HALF - 1);
   localparam logic [LOGN-1:0] S_LAST = LOGN'(LOGN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t          state;
   logic [LOGN-1:0] j;
   logic            issue_q;
   logic            stall_i;
   logic [IW-1:0]   inflight;
   logic [DW-1:0]   dly [PIPE];

   logic [LOGN-1:0] ld_s, ld_j, d, g, k;
   logic [LOGN-1:0] a_top, a_bot, a_tw;
   int              sh;

`ifdef NTT_SCHED_STALL_EN
   assign stall_i = stall;
`else
   assign stall_i = 1'b0;
`endif

   assign rd_en = issue_q & ~stall_i;

   // Address of the butterfly that will be issued after the next edge.
   always_comb begin
      ld_s = stage;
      ld_j = j + ONE;
      if (state == S_IDLE) begin
         ld_s = '0;
         ld_j = '0;
      end else if (state == S_DRAIN) begin
         ld_s = stage + ONE;
         ld_j = '0;
      end
      sh    = LOGN - 1 - int'(ld_s);
      d     = LOGN'(HALF >> ld_s);
      g     = ld_j >> sh;
      k     = ld_j & (d - ONE);
      a_top = (g << (sh + 1)) | k;
      a_bot = a_top + d;
      a_tw  = (ONE << ld_s) + g;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         stage   <= '0;
         j       <= '0;
         issue_q <= 1'b0;
         rd_top  <= '0;
         rd_bot  <= '0;
         tw_addr <= '0;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_RUN;
                  stage   <= '0;
                  j       <= '0;
                  issue_q <= 1'b1;
                  rd_top  <= a_top;
                  rd_bot  <= a_bot;
                  tw_addr <= a_tw;
                  ready   <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            S_RUN: begin
               if (rd_en) begin
                  if (j == J_LAST) begin
                     state   <= S_DRAIN;
                     issue_q <= 1'b0;
                  end else begin
                     j       <= j + ONE;
                     rd_top  <= a_top;
                     rd_bot  <= a_bot;
                     tw_addr <= a_tw;
                  end
               end
            end
            S_DRAIN: begin
               if (inflight == '0) begin
                  if (stage == S_LAST) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state   <= S_RUN;
                     stage   <= stage + ONE;
                     j       <= '0;
                     issue_q <= 1'b1;
                     rd_top  <= a_top;
                     rd_bot  <= a_bot;
                     tw_addr <= a_tw;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inflight <= '0;
      end else begin
         case ({rd_en, wr_en})
            2'b10:   inflight <= inflight + IW'(1);
            2'b01:   inflight <= inflight - IW'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   // Write-back addresses ride alongside the datapath for PIPE cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < PIPE; i++) dly[i] <= '0;
      end else begin
         dly[0] <= rd_en ? {1'b1, rd_top, rd_bot} : '0;
         for (int i = 1; i < PIPE; i++) dly[i] <= dly[i-1];
      end
   end

   assign {wr_en, wr_top, wr_bot} = dly[PIPE-1];

endmodule

// File: tb/tb_ntt_stage_sched.sv
// Directed bench for ntt_stage_sched at LOGN=3 with PIPE=4 and PIPE=8.
// Outputs are logged per cycle at the falling edge and compared to hand tables.
module tb_ntt_stage_sched;

   localparam int L  = 3;
   localparam int LS = 128;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         start8 = 1'b0;
`ifdef NTT_SCHED_STALL_EN
   logic         stall = 1'b0;
`endif

   logic         ready, busy, done, rd_en, wr_en;
   logic [L-1:0] stage, rd_top, rd_bot, tw_addr, wr_top, wr_bot;
   logic         ready8, busy8, done8, rd_en8, wr_en8;
   logic [L-1:0] stage8, rd_top8, rd_bot8, tw_addr8, wr_top8, wr_bot8;

   ntt_stage_sched #(.LOGN(L), .PIPE(4)) dut (
      .clk(clk), .reset(reset), .start(start),
`ifdef NTT_SCHED_STALL_EN
      .stall(stall),
`endif
      .ready(ready), .busy(busy), .done(done), .stage(stage),
      .rd_en(rd_en), .rd_top(rd_top), .rd_bot(rd_bot), .tw_addr(tw_addr),
      .wr_en(wr_en), .wr_top(wr_top), .wr_bot(wr_bot)
   );

   ntt_stage_sched #(.LOGN(L), .PIPE(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8),
`ifdef NTT_SCHED_STALL_EN
      .stall(1'b0),
`endif
      .ready(ready8), .busy(busy8), .done(done8), .stage(stage8),
      .rd_en(rd_en8), .rd_top(rd_top8), .rd_bot(rd_bot8), .tw_addr(tw_addr8),
      .wr_en(wr_en8), .wr_top(wr_top8), .wr_bot(wr_bot8)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int base = 0;
   int n_cmp = 0;
   int n_bad = 0;

   int l_rd[LS], l_top[LS], l_bot[LS], l_tw[LS], l_stg[LS];
   int l_wr[LS], l_wtop[LS], l_wbot[LS], l_done[LS], l_ready[LS], l_busy[LS];
   int l8_rd[LS], l8_stg[LS], l8_wr[LS], l8_done[LS];

   // Stage-ordered issue table for one LOGN=3 transform.
   int ic[12] = '{1, 2, 3, 4, 10, 11, 12, 13, 19, 20, 21, 22};
   int it[12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
   int ib[12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
   int iw[12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};
   int e_rd[LS], e_top[LS], e_bot[LS], e_tw[LS], e_stg[LS];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      int i;
      i = cyc - base;
      if (i >= 0 && i < LS) begin
         l_rd[i]    = int'(rd_en);
         l_top[i]   = int'(rd_top);
         l_bot[i]   = int'(rd_bot);
         l_tw[i]    = int'(tw_addr);
         l_stg[i]   = int'(stage);
         l_wr[i]    = int'(wr_en);
         l_wtop[i]  = int'(wr_top);
         l_wbot[i]  = int'(wr_bot);
         l_done[i]  = int'(done);
         l_ready[i] = int'(ready);
         l_busy[i]  = int'(busy);
         l8_rd[i]   = int'(rd_en8);
         l8_stg[i]  = int'(stage8);
         l8_wr[i]   = int'(wr_en8);
         l8_done[i] = int'(done8);
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sync0();
      @(posedge clk);
      #1;
      base = cyc;
      for (int i = 0; i < LS; i++) begin
         l_rd[i] = 0; l_wr[i] = 0; l_done[i] = 0;
         l8_rd[i] = 0; l8_wr[i] = 0; l8_done[i] = 0;
      end
   endtask

   initial begin
      for (int i = 0; i < LS; i++) begin
         e_rd[i] = 0; e_top[i] = 0; e_bot[i] = 0; e_tw[i] = 0; e_stg[i] = 0;
      end
      for (int i = 0; i < 12; i++) begin
         e_rd[ic[i]]  = 1;
         e_top[ic[i]] = it[i];
         e_bot[ic[i]] = ib[i];
         e_tw[ic[i]]  = iw[i];
         e_stg[ic[i]] = i / 4;
      end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", int'(ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_rd_en", int'(rd_en), 0);
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_stage", int'(stage), 0);
      reset = 1'b1;
      repeat (2) step();

      // Full transform, PIPE=4
      sync0();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (31) step();
      chk("t1_ready0", l_ready[0], 1);
      for (int c = 1; c < 32; c++) begin
         chk($sformatf("t1_rd_en@%0d", c), l_rd[c], e_rd[c]);
         chk($sformatf("t1_wr_en@%0d", c), l_wr[c], (c >= 5) ? e_rd[c-4] : 0);
         chk($sformatf("t1_done@%0d", c), l_done[c], (c == 28) ? 1 : 0);
         if (e_rd[c] == 1) begin
            chk($sformatf("t1_top@%0d", c), l_top[c], e_top[c]);
            chk($sformatf("t1_bot@%0d", c), l_bot[c], e_bot[c]);
            chk($sformatf("t1_tw@%0d", c), l_tw[c], e_tw[c]);
            chk($sformatf("t1_stage@%0d", c), l_stg[c], e_stg[c]);
         end
         if (c >= 5 && e_rd[c-4] == 1) begin
            chk($sformatf("t1_wtop@%0d", c), l_wtop[c], e_top[c-4]);
            chk($sformatf("t1_wbot@%0d", c), l_wbot[c], e_bot[c-4]);
         end
      end
      chk("t1_busy_drain", l_busy[7], 1);
      chk("t1_busy_done", l_busy[28], 0);
      chk("t1_ready_end", l_ready[29], 1);
      chk("t1_ready_run", l_ready[15], 0);

      // Reset in the middle of stage 0
      sync0();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      reset = 1'b0;
      #1;
      chk("t2_rst_ready", int'(ready), 1);
      chk("t2_rst_busy", int'(busy), 0);
      chk("t2_rst_wr_en", int'(wr_en), 0);
      chk("t2_rst_rd_en", int'(rd_en), 0);
      chk("t2_rst_stage", int'(stage), 0);
      step();
      reset = 1'b1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (31) step();
      for (int c = 7; c < 13; c++)
         chk($sformatf("t2_no_wr@%0d", c), l_wr[c], 0);
      chk("t2_rd_en@8", l_rd[8], 0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t2_rd_en@%0d", 9 + i), l_rd[9+i], 1);
         chk($sformatf("t2_top@%0d", 9 + i), l_top[9+i], it[i]);
         chk($sformatf("t2_bot@%0d", 9 + i), l_bot[9+i], ib[i]);
         chk($sformatf("t2_tw@%0d", 9 + i), l_tw[9+i], iw[i]);
      end
      chk("t2_done@36", l_done[36], 1);

      // Start pulses while busy are dropped
      sync0();
      for (int c = 0; c < 60; c++) begin
         start = (c == 0 || c == 3 || c == 20);
         step();
      end
      start = 1'b0;
      begin
         int nd, nr_a, nr_b;
         nd = 0; nr_a = 0; nr_b = 0;
         for (int c = 1; c < 60; c++) begin
            nd += l_done[c];
            if (c <= 28) nr_a += l_rd[c];
            else nr_b += l_rd[c];
         end
         chk("t3_done_count", nd, 1);
         chk("t3_done@28", l_done[28], 1);
         chk("t3_issues", nr_a, 12);
         chk("t3_no_restart", nr_b, 0);
      end

      // Start held high: back-to-back transforms
      sync0();
      for (int c = 0; c < 90; c++) begin
         start = (c < 87);
         step();
      end
      start = 1'b0;
      begin
         int nd;
         nd = 0;
         for (int c = 1; c < 90; c++) nd += l_done[c];
         chk("t4_done_count", nd, 3);
      end
      chk("t4_done@28", l_done[28], 1);
      chk("t4_done@57", l_done[57], 1);
      chk("t4_done@86", l_done[86], 1);
      chk("t4_rd_en@30", l_rd[30], 1);
      chk("t4_top@39", l_top[39], 0);
      chk("t4_bot@39", l_bot[39], 2);
      chk("t4_rd_en@88", l_rd[88], 0);
      chk("t4_ready@89", l_ready[89], 1);

      // Drain barrier, PIPE=8
      sync0();
      for (int c = 0; c < 45; c++) begin
         start8 = (c == 0);
         step();
      end
      start8 = 1'b0;
      begin
         int inf, pk, nw, last_w0, first_r1, inf_at;
         inf = 0; pk = 0; nw = 0; last_w0 = -1; first_r1 = -1; inf_at = -1;
         for (int c = 0; c < 45; c++) begin
            if (first_r1 < 0 && l8_rd[c] == 1 && l8_stg[c] == 1) begin
               first_r1 = c;
               inf_at = inf;
            end
            if (l8_wr[c] == 1) begin
               nw++;
               if (nw == 4) last_w0 = c;
            end
            inf += l8_rd[c] - l8_wr[c];
            if (inf > pk) pk = inf;
         end
         chk("t5_last_s0_wr", last_w0, 12);
         chk("t5_first_s1_rd", first_r1, 14);
         chk("t5_barrier", (first_r1 > last_w0) ? 1 : 0, 1);
         chk("t5_inflight_peak", pk, 4);
         chk("t5_inflight_exit", inf_at, 0);
         chk("t5_done@40", l8_done[40], 1);
      end

`ifdef NTT_SCHED_STALL_EN
      // Stall during stage 0 issue
      sync0();
      for (int c = 0; c < 35; c++) begin
         start = (c == 0);
         stall = (c == 2 || c == 3);
         step();
      end
      start = 1'b0;
      stall = 1'b0;
      chk("t6_rd_en@1", l_rd[1], 1);
      chk("t6_rd_en@2", l_rd[2], 0);
      chk("t6_rd_en@3", l_rd[3], 0);
      chk("t6_rd_en@4", l_rd[4], 1);
      chk("t6_rd_en@5", l_rd[5], 1);
      chk("t6_rd_en@6", l_rd[6], 1);
      chk("t6_rd_en@7", l_rd[7], 0);
      chk("t6_top@1", l_top[1], 0);
      chk("t6_top@4", l_top[4], 1);
      chk("t6_top@5", l_top[5], 2);
      chk("t6_bot@6", l_bot[6], 7);
      chk("t6_done@30", l_done[30], 1);
      chk("t6_done@28", l_done[28], 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
